// File: rtl/regfile_operand_stage_if.sv
// Operand-stage register file bus: write port, exception write path and two read ports.
interface regfile_operand_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic                  ctrl_excWrite;
  logic [DATA_WIDTH-1:0] data_excCode;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_excWrite, data_excCode,
    output ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_excWrite, data_excCode,
    input  ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );
endinterface

// File: rtl/regfile_operand_stage.sv
// 32x32 register file feeding the ALU operands, with a dedicated exception write into the status register.
// Define REGFILE_BYPASS_EN to forward the current-cycle writes onto both read ports.
module regfile_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STATUS_REG = 30
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  regfile_operand_stage_if.slave   bus
);
  localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = ADDR_WIDTH'(STATUS_REG);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX   = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r    [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_idx_s  [2];
  logic [DATA_WIDTH-1:0] rd_data_s [2];

  assign rd_idx_s[0]       = bus.ctrl_readRegA;
  assign rd_idx_s[1]       = bus.ctrl_readRegB;
  assign bus.data_readRegA = rd_data_s[0];
  assign bus.data_readRegB = rd_data_s[1];

  // Storage update: the exception path owns the status register when it fires; index 0 is never written.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.ctrl_excWrite && (ADDR_WIDTH'(i) == STATUS_IDX)) begin
          regs_r[i] <= bus.data_excCode;
        end else if (bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_WIDTH'(i))) begin
          regs_r[i] <= bus.data_writeReg;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read ports: index 0 is forced to zero ahead of any forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {DATA_WIDTH{1'b0}};
      if (rd_idx_s[p] == ZERO_IDX) begin
        rd_data_s[p] = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (bus.ctrl_excWrite && (rd_idx_s[p] == STATUS_IDX)) begin
        rd_data_s[p] = bus.data_excCode;
      end else if (bus.ctrl_writeEnable && (rd_idx_s[p] == bus.ctrl_writeReg)) begin
        rd_data_s[p] = bus.data_writeReg;
`endif
      end else begin
        rd_data_s[p] = regs_r[rd_idx_s[p]];
      end
    end
  end
endmodule

// File: tb/tb_regfile_operand_stage.sv
// Directed, table-driven bench for regfile_operand_stage; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_operand_stage;
  logic clock      = 1'b0;
  logic ctrl_reset = 1'b1;
  int   checks     = 0;
  int   failures   = 0;

  regfile_operand_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STATUS_REG(30)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        exc;
    logic [31:0] ecode;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'h0000_0000;
    bus.ctrl_excWrite    = 1'b0;
    bus.data_excCode     = 32'h0000_0000;
  endtask

  initial begin
    logic [31:0] exp_bypass;

    // {we, wreg, wdata, exc, ecode, ra, rb, exp_a, exp_b}; checked after the edge with strobes dropped.
    vecs[0] = '{1'b1, 5'd1,  32'h0000_0001, 1'b0, 32'h0, 5'd1,  5'd0,  32'h0000_0001, 32'h0000_0000};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd1,  5'd31, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 32'h0, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 5'd0,  32'h1234_5678, 1'b0, 32'h0, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 5'd30, 32'hAAAA_AAAA, 1'b1, 32'h0000_0001, 5'd30, 5'd30, 32'h0000_0001, 32'h0000_0001};
    vecs[5] = '{1'b1, 5'd7,  32'h8000_0000, 1'b1, 32'h0000_0003, 5'd30, 5'd7,  32'h0000_0003, 32'h8000_0000};
    vecs[6] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'h0, 5'd5,  5'd1,  32'hDEAD_BEEF, 32'h0000_0001};
    vecs[7] = '{1'b1, 5'd12, 32'hA5A5_A5A5, 1'b0, 32'h0, 5'd12, 5'd7,  32'hA5A5_A5A5, 32'h8000_0000};

    idle_bus();
    bus.ctrl_readRegA = 5'd0;
    bus.ctrl_readRegB = 5'd0;

    #2 ctrl_reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.ctrl_readRegA = 5'(i);
      bus.ctrl_readRegB = 5'(31 - i);
      #1;
      check($sformatf("reset_a_r%0d", i), bus.data_readRegA, 32'h0000_0000);
      check($sformatf("reset_b_r%0d", 31 - i), bus.data_readRegB, 32'h0000_0000);
    end
    @(negedge clock);
    ctrl_reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      @(negedge clock);
      bus.ctrl_writeEnable = vecs[v].we;
      bus.ctrl_writeReg    = vecs[v].wreg;
      bus.data_writeReg    = vecs[v].wdata;
      bus.ctrl_excWrite    = vecs[v].exc;
      bus.data_excCode     = vecs[v].ecode;
      bus.ctrl_readRegA    = vecs[v].ra;
      bus.ctrl_readRegB    = vecs[v].rb;
      @(posedge clock);
      #1;
      idle_bus();
      #1;
      check($sformatf("vec%0d_a", v), bus.data_readRegA, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), bus.data_readRegB, vecs[v].exp_b);
    end

    // Index-0 write held active while reading index 0: forwarding must not leak it.
    @(negedge clock);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'h1234_5678;
    bus.ctrl_readRegA    = 5'd0;
    bus.ctrl_readRegB    = 5'd0;
    #1;
    check("r0_live_write_a", bus.data_readRegA, 32'h0000_0000);
    check("r0_live_write_b", bus.data_readRegB, 32'h0000_0000);

    // Read-during-write of r9 alongside an exception write to r30.
    @(negedge clock);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd9;
    bus.data_writeReg    = 32'h7FFF_FFFF;
    bus.ctrl_excWrite    = 1'b1;
    bus.data_excCode     = 32'h0000_0005;
    bus.ctrl_readRegA    = 5'd9;
    bus.ctrl_readRegB    = 5'd30;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_bypass = 32'h7FFF_FFFF;
    check("rdw_pre_a", bus.data_readRegA, exp_bypass);
    exp_bypass = 32'h0000_0005;
    check("rdw_pre_b", bus.data_readRegB, exp_bypass);
`else
    exp_bypass = 32'h0000_0000;
    check("rdw_pre_a", bus.data_readRegA, exp_bypass);
    exp_bypass = 32'h0000_0003;
    check("rdw_pre_b", bus.data_readRegB, exp_bypass);
`endif
    @(posedge clock);
    #1;
    idle_bus();
    #1;
    check("rdw_post_a", bus.data_readRegA, 32'h7FFF_FFFF);
    check("rdw_post_b", bus.data_readRegB, 32'h0000_0005);

    // Mid-cycle reset clears r5 at once; a write pending at the edge during reset is lost.
    @(negedge clock);
    bus.ctrl_readRegA = 5'd5;
    bus.ctrl_readRegB = 5'd9;
    #1;
    check("pre_reset_r5", bus.data_readRegA, 32'hDEAD_BEEF);
    #1 ctrl_reset = 1'b0;
    #1;
    check("async_reset_r5", bus.data_readRegA, 32'h0000_0000);
    check("async_reset_r9", bus.data_readRegB, 32'h0000_0000);
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd5;
    bus.data_writeReg    = 32'h5555_5555;
    bus.ctrl_excWrite    = 1'b1;
    bus.data_excCode     = 32'h0000_0009;
    bus.ctrl_readRegB    = 5'd30;
    @(posedge clock);
    #1;
    idle_bus();
    #1;
    check("reset_dominates_r5", bus.data_readRegA, 32'h0000_0000);
    check("reset_dominates_r30", bus.data_readRegB, 32'h0000_0000);

    // First write after release lands at the first edge.
    @(negedge clock);
    ctrl_reset           = 1'b1;
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd2;
    bus.data_writeReg    = 32'h0BAD_F00D;
    bus.ctrl_readRegA    = 5'd2;
    bus.ctrl_readRegB    = 5'd2;
    @(posedge clock);
    #1;
    idle_bus();
    #1;
    check("first_write_a", bus.data_readRegA, 32'h0BAD_F00D);
    check("first_write_b", bus.data_readRegB, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_operand_stage.md
Name: regfile_operand_stage

Overview:
- Register file that sources data_operandA / data_operandB for the ALU. It sits directly upstream of the ALU.
- 32 x 32-bit storage, two combinational read ports, one clocked write port.
- Dedicated exception write path: the ALU overflow result is recorded into the status register ($rstatus) without stealing the normal write port.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH = 32.
- STATUS_REG, 30, index of the status register targeted by the exception write path.

Ports:
- clock  input  1  rising-edge clock for all state.
- ctrl_reset  input  1  asynchronous, active-low reset; 0 clears all registers.
- ctrl_writeEnable  input  1  normal write strobe, sampled at posedge clock.
- ctrl_writeReg  input  ADDR_WIDTH  normal write index.
- data_writeReg  input  DATA_WIDTH  normal write data.
- ctrl_excWrite  input  1  exception write strobe, asserted by the execute stage on ALU overflow.
- data_excCode  input  DATA_WIDTH  value written to STATUS_REG on an exception write.
- ctrl_readRegA  input  ADDR_WIDTH  read index, port A.
- ctrl_readRegB  input  ADDR_WIDTH  read index, port B.
- data_readRegA  output  DATA_WIDTH  port A data; feeds ALU data_operandA.
- data_readRegB  output  DATA_WIDTH  port B data; feeds ALU data_operandB.

Behaviour:
- Reset:
  - ctrl_reset=0 clears registers 0..31 to 32'h00000000 immediately, independent of clock.
  - Both read outputs show 0 within the same delta.
  - Reset dominates any write pending at the same edge.
  - Release is synchronous-safe: the first write is accepted at the first posedge after ctrl_reset=1.
- Normal write:
  - At posedge, if ctrl_writeEnable=1 and ctrl_writeReg!=0, the register takes data_writeReg.
  - Write latency is 1 cycle; the value is visible on the read ports after the edge.
- Register 0:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, including with the bypass enabled.
- Exception write:
  - At posedge, if ctrl_excWrite=1, STATUS_REG takes data_excCode.
- Simultaneous events:
  - ctrl_excWrite=1 together with a normal write to STATUS_REG: the exception value wins and the normal write is dropped.
  - ctrl_excWrite=1 together with a normal write to any other index: both writes commit in the same cycle.
- Reads:
  - Purely combinational from ctrl_readRegA / ctrl_readRegB.
  - Both ports may address the same register and return identical data.
- Read-during-write (feature off): a read returns the pre-edge (old) value until the posedge commits the write.
- Arithmetic: no arithmetic in this block; all data passes unmodified at full DATA_WIDTH.
- Undriven or X inputs: no requirement, except that register 0 still reads 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding on each read port, applied combinationally in this priority order:
  1. Read index = 0 -> output 0.
  2. ctrl_excWrite=1 and read index = STATUS_REG -> output data_excCode.
  3. ctrl_writeEnable=1 and read index = ctrl_writeReg -> output data_writeReg.
  4. Otherwise -> stored value.
- Forwarding applies to the current-cycle write, so the ALU receives the new operand without a stall.
- Undefined: no forwarding; reads are purely from storage, with 1-cycle read-after-write latency as described under Behaviour.

Test Plan:
- Reset -> read all indices: every index reads 32'h00000000; pulse ctrl_reset=0 mid-cycle after writing r5=32'hDEADBEEF -> r5 reads 0 immediately, before the next edge.
- Write r1=32'h00000001 and r31=32'hFFFFFFFF on consecutive cycles; read A=r1, B=r31 -> 00000001 / FFFFFFFF; read A=B=r31 -> both FFFFFFFF.
- Write index 0 with 32'h12345678 -> r0 reads 0 on both ports, with and without REGFILE_BYPASS_EN.
- Same edge: ctrl_excWrite=1 with data_excCode=32'h00000001, and normal write r30=32'hAAAAAAAA -> r30 reads 00000001.
- Same edge: ctrl_excWrite=1 with data_excCode=32'h00000003, and normal write r7=32'h80000000 -> r30 reads 00000003 and r7 reads 80000000.
- Read-during-write of r9=32'h7FFFFFFF (old value 0), sampled before the edge:
  - Macro off -> port reads 0.
  - Macro on -> port reads 7FFFFFFF.
  - Both builds -> port reads 7FFFFFFF after the edge.
